reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Parametrised architectural register file with integrated rename (ROB-tag) table for the out-of-order core. It sits between the dispatcher, which renames destinations and reads source operands, and the reorder buffer, which commits results and signals flush. Compared with the current register/tag store, it provides:
- `NUM_RD` independent source read ports with same-cycle commit bypass.
- An explicit busy bit per register instead of a reserved tag value.
- A registered pending-register count.
- Optional branch checkpoints for partial rollback.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG`, 32, architectural register count; x0 is hardwired to zero.
- `ROB_W`, 4, ROB tag width.
- `NUM_RD`, 2, number of source read ports.
- `CKPT_NUM`, 4, checkpoint slots (used only with `REGFILE_CKPT_EN`).

Ports (all widths in bits):
- `clk_in`  input  1  clock; all state updates on rising edge.
- `rst_in`  input  1  reset, asynchronous, active-low.
- `rdy_in`  input  1  global stall; when low, no state changes.
- `rn_valid_in`  input  1  dispatcher renames a destination this cycle.
- `rn_rd_in`  input  log2(NREG)  destination register.
- `rn_tag_in`  input  ROB_W  ROB tag of the producing instruction.
- `rd_addr_in`  input  NUM_RD*log2(NREG)  packed source register indices.
- `rd_data_out`  output  NUM_RD*XLEN  packed source values.
- `rd_busy_out`  output  NUM_RD  source still pending.
- `rd_tag_out`  output  NUM_RD*ROB_W  producing tag; valid when busy.
- `cm_valid_in`  input  1  ROB commits a register write.
- `cm_rd_in`  input  log2(NREG)  committed register.
- `cm_tag_in`  input  ROB_W  committing tag.
- `cm_data_in`  input  XLEN  committed value.
- `flush_in`  input  1  full pipeline flush.
- `pending_cnt_out`  output  log2(NREG)+1  registered count of busy registers.
- `ck_save_in`  input  1  (macro only) take a checkpoint.
- `ck_id_in`  input  log2(CKPT_NUM)  (macro only) slot to save into.
- `ck_restore_in`  input  1  (macro only) restore a slot.
- `ck_rid_in`  input  log2(CKPT_NUM)  (macro only) slot to restore.

## Operation
- **Per-register state:** `data`, `busy`, `tag`. Reset clears all three, so all outputs are 0.
- **Reads** are combinational, per port *p*, with index *r* = `rd_addr_in[p]`:
  - *r* = 0: data 0, busy 0, tag 0.
  - Else if `cm_valid_in`, `cm_rd_in` = *r*, busy[*r*] is set and tag[*r*] = `cm_tag_in`: data = `cm_data_in`, busy 0.
  - Else if `cm_valid_in` and `cm_rd_in` = *r*, but the stored tag does not match: data = `cm_data_in`, busy and tag taken from the table.
  - Otherwise: table contents.
  - Reads never see the same-cycle rename. A source that equals its own destination gets the old mapping.
- **Commit** (`cm_valid_in`, `cm_rd_in` ≠ 0):
  - data[rd] ← `cm_data_in`.
  - busy[rd] is cleared only if tag[rd] = `cm_tag_in` and there is no same-cycle rename of rd.
- **Rename** (`rn_valid_in`, `rn_rd_in` ≠ 0): busy ← 1, tag ← `rn_tag_in`.
  - Rename wins over a commit to the same register in the same cycle.
- **Flush:** all busy bits and tags are cleared.
  - Flush has priority over rename.
  - A same-cycle commit still writes its data, because it is architecturally retired.
- **`pending_cnt_out`:** popcount of busy[1..NREG-1] after the update, registered. Range 0..NREG-1.
- **Stall:** with `rdy_in` low, all inputs are ignored for state; reads stay live.

## Timing
- Read latency is 0 cycles. Commit is visible on reads in the same cycle via the bypass.
- Rename is visible on reads from the next cycle.
- `pending_cnt_out` updates one cycle after the event that changes it.
- Asynchronous reset takes effect immediately, including mid-flush or mid-checkpoint. All checkpoint slots are cleared.
- Tag wrap-around is the ROB's responsibility. Tags are compared by equality only.

## Configuration
- **Macro `REGFILE_CKPT_EN` defined:**
  - The `ck_*` ports and `CKPT_NUM` slots of {busy, tag} exist.
  - **Save:** `ck_save_in` stores the post-update table from that cycle, including that cycle's rename and commit.
  - **Commit propagation:** every commit also clears the matching busy bit in every slot whose stored tag equals `cm_tag_in`.
  - **Restore:** `ck_restore_in` loads slot `ck_rid_in`, with the same-cycle commit clear applied. Rename is dropped in that cycle.
  - **Priority:** `flush_in` > `ck_restore_in` > rename. Save together with restore is illegal.
- **Macro undefined:** no `ck_*` ports and no checkpoint storage. Flush is the only rollback.

## Test plan
- **Reset/x0:** reset, then rename x0 with tag 3 and commit x0 with value 5 → x0 reads data 0, busy 0; `pending_cnt_out` = 0.
- **Rename then commit:** rename x5 with tag 2; next cycle x5 reads busy 1, tag 2. Commit x5 = 0xDEAD with tag 2 → the same-cycle read gives 0xDEAD, busy 0; `pending_cnt_out` goes 1 → 0.
- **Stale commit:** rename x7 with tag 1, then x7 with tag 4. Commit x7 = 9 with tag 1 → x7 still busy with tag 4; data = 9.
- **Simultaneous commit + rename:** x3 busy with tag 2; in one cycle commit x3 with tag 2 and rename x3 with tag 6 → next cycle busy 1, tag 6.
- **Flush:** 10 registers busy; flush together with a commit of x4 = 0x11 → all busy 0, x4 = 0x11; `pending_cnt_out` = 0.
- **Checkpoint (macro):** save slot 1 with x8 busy on tag 2; commit tag 2; rename x9 with tag 5; restore slot 1 → x8 not busy, x9 not busy.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy/ROB-tag rename table and commit bypass.
// Optional branch checkpoints of {busy, tag} are compiled in with `define REGFILE_CKPT_EN.
module reg_rename_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned CKPT_NUM = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             rn_valid_in,
    input  logic [$clog2(NREG)-1:0]          rn_rd_in,
    input  logic [ROB_W-1:0]                 rn_tag_in,
    input  logic [NUM_RD*$clog2(NREG)-1:0]   rd_addr_in,
    output logic [NUM_RD*XLEN-1:0]           rd_data_out,
    output logic [NUM_RD-1:0]                rd_busy_out,
    output logic [NUM_RD*ROB_W-1:0]          rd_tag_out,
    input  logic                             cm_valid_in,
    input  logic [$clog2(NREG)-1:0]          cm_rd_in,
    input  logic [ROB_W-1:0]                 cm_tag_in,
    input  logic [XLEN-1:0]                  cm_data_in,
    input  logic                             flush_in,
    output logic [$clog2(NREG):0]            pending_cnt_out
`ifdef REGFILE_CKPT_EN
    ,
    input  logic                             ck_save_in,
    input  logic [$clog2(CKPT_NUM)-1:0]      ck_id_in,
    input  logic                             ck_restore_in,
    input  logic [$clog2(CKPT_NUM)-1:0]      ck_rid_in
`endif
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0]  r_data [NREG];
    logic [NREG-1:0]  r_busy;
    logic [ROB_W-1:0] r_tag  [NREG];
    logic [AW:0]      r_pend;

    logic [NREG-1:0]  w_busy_nxt;
    logic [ROB_W-1:0] w_tag_nxt [NREG];
    logic [AW:0]      w_pend_nxt;
    logic             w_cm_live;
    logic             w_cm_hit;
    logic             w_rn_live;
    logic [AW-1:0]    w_ra [NUM_RD];

    assign w_cm_live = cm_valid_in && (cm_rd_in != '0);
    assign w_cm_hit  = w_cm_live && (r_tag[cm_rd_in] == cm_tag_in);
    assign w_rn_live = rn_valid_in && (rn_rd_in != '0);

`ifdef REGFILE_CKPT_EN
    localparam int unsigned CW = $clog2(CKPT_NUM);

    logic [NREG-1:0]  r_ck_busy [CKPT_NUM];
    logic [ROB_W-1:0] r_ck_tag  [CKPT_NUM][NREG];
    logic [NREG-1:0]  w_ck_busy_cl [CKPT_NUM];

    // Commits retire in every checkpoint too, so a restore never resurrects a done producer.
    always_comb begin
        for (int s = 0; s < CKPT_NUM; s++) begin
            w_ck_busy_cl[s] = r_ck_busy[s];
            if (w_cm_live && (r_ck_tag[s][cm_rd_in] == cm_tag_in)) begin
                w_ck_busy_cl[s][cm_rd_in] = 1'b0;
            end
        end
    end
`endif

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREG; i++) begin
            w_tag_nxt[i] = r_tag[i];
        end
        if (flush_in) begin
            w_busy_nxt = '0;
            for (int i = 0; i < NREG; i++) begin
                w_tag_nxt[i] = '0;
            end
        end
`ifdef REGFILE_CKPT_EN
        else if (ck_restore_in) begin
            w_busy_nxt = w_ck_busy_cl[ck_rid_in];
            for (int i = 0; i < NREG; i++) begin
                w_tag_nxt[i] = r_ck_tag[ck_rid_in][i];
            end
        end
`endif
        else begin
            if (w_cm_hit) begin
                w_busy_nxt[cm_rd_in] = 1'b0;
            end
            if (w_rn_live) begin
                w_busy_nxt[rn_rd_in] = 1'b1;
                w_tag_nxt[rn_rd_in]  = rn_tag_in;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_pend_nxt = w_pend_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= '0;
            r_pend <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            r_busy <= w_busy_nxt;
            r_pend <= w_pend_nxt;
            for (int i = 0; i < NREG; i++) begin
                r_tag[i] <= w_tag_nxt[i];
            end
            // Retired data lands even under flush.
            if (w_cm_live) begin
                r_data[cm_rd_in] <= cm_data_in;
            end
        end
    end

`ifdef REGFILE_CKPT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < CKPT_NUM; s++) begin
                r_ck_busy[s] <= '0;
                for (int i = 0; i < NREG; i++) begin
                    r_ck_tag[s][i] <= '0;
                end
            end
        end else if (rdy_in) begin
            for (int s = 0; s < CKPT_NUM; s++) begin
                if (ck_save_in && (ck_id_in == CW'(s))) begin
                    r_ck_busy[s] <= w_busy_nxt;
                    for (int i = 0; i < NREG; i++) begin
                        r_ck_tag[s][i] <= w_tag_nxt[i];
                    end
                end else begin
                    r_ck_busy[s] <= w_ck_busy_cl[s];
                end
            end
        end
    end
`endif

    // Reads see the same-cycle commit but never the same-cycle rename.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra[p] = rd_addr_in[p*AW +: AW];
            rd_data_out[p*XLEN +: XLEN] = '0;
            rd_busy_out[p]              = 1'b0;
            rd_tag_out[p*ROB_W +: ROB_W] = '0;
            if (w_ra[p] != '0) begin
                rd_data_out[p*XLEN +: XLEN]  = r_data[w_ra[p]];
                rd_busy_out[p]               = r_busy[w_ra[p]];
                rd_tag_out[p*ROB_W +: ROB_W] = r_tag[w_ra[p]];
                if (cm_valid_in && (cm_rd_in == w_ra[p])) begin
                    rd_data_out[p*XLEN +: XLEN] = cm_data_in;
                    if (r_busy[w_ra[p]] && (r_tag[w_ra[p]] == cm_tag_in)) begin
                        rd_busy_out[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign pending_cnt_out = r_pend;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file (default parameters).
module tb_reg_rename_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rn_valid_in;
    logic [4:0]  rn_rd_in;
    logic [3:0]  rn_tag_in;
    logic [9:0]  rd_addr_in;
    logic [63:0] rd_data_out;
    logic [1:0]  rd_busy_out;
    logic [7:0]  rd_tag_out;
    logic        cm_valid_in;
    logic [4:0]  cm_rd_in;
    logic [3:0]  cm_tag_in;
    logic [31:0] cm_data_in;
    logic        flush_in;
    logic [5:0]  pending_cnt_out;
    logic        ck_save_in;
    logic [1:0]  ck_id_in;
    logic        ck_restore_in;
    logic [1:0]  ck_rid_in;

    int ntot = 0;
    int nbad = 0;

    reg_rename_file dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rn_valid_in     (rn_valid_in),
        .rn_rd_in        (rn_rd_in),
        .rn_tag_in       (rn_tag_in),
        .rd_addr_in      (rd_addr_in),
        .rd_data_out     (rd_data_out),
        .rd_busy_out     (rd_busy_out),
        .rd_tag_out      (rd_tag_out),
        .cm_valid_in     (cm_valid_in),
        .cm_rd_in        (cm_rd_in),
        .cm_tag_in       (cm_tag_in),
        .cm_data_in      (cm_data_in),
        .flush_in        (flush_in),
        .pending_cnt_out (pending_cnt_out)
`ifdef REGFILE_CKPT_EN
        ,
        .ck_save_in      (ck_save_in),
        .ck_id_in        (ck_id_in),
        .ck_restore_in   (ck_restore_in),
        .ck_rid_in       (ck_rid_in)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic idle();
        rdy_in        = 1'b1;
        rn_valid_in   = 1'b0;
        rn_rd_in      = '0;
        rn_tag_in     = '0;
        cm_valid_in   = 1'b0;
        cm_rd_in      = '0;
        cm_tag_in     = '0;
        cm_data_in    = '0;
        flush_in      = 1'b0;
        ck_save_in    = 1'b0;
        ck_id_in      = '0;
        ck_restore_in = 1'b0;
        ck_rid_in     = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
        rn_valid_in = 1'b1;
        rn_rd_in    = rd;
        rn_tag_in   = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] d);
        cm_valid_in = 1'b1;
        cm_rd_in    = rd;
        cm_tag_in   = tag;
        cm_data_in  = d;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b0;
        rd_addr_in = {5'd9, 5'd5};
        #2;
        ntot++; if (rd_data_out !== 64'h0) begin nbad++; $display("FAIL reset_data got=%h exp=0", rd_data_out); end
        ntot++; if (rd_busy_out !== 2'b00) begin nbad++; $display("FAIL reset_busy got=%b exp=00", rd_busy_out); end
        ntot++; if (rd_tag_out !== 8'h0) begin nbad++; $display("FAIL reset_tag got=%h exp=0", rd_tag_out); end
        ntot++; if (pending_cnt_out !== 6'd0) begin nbad++; $display("FAIL reset_pend got=%0d exp=0", pending_cnt_out); end
        #1;
        rst_in = 1'b1;
    endtask

    task automatic test_x0();
        rename(5'd0, 4'd3);
        commit(5'd0, 4'd3, 32'd5);
        rd_addr_in = {5'd0, 5'd0};
        #1;
        ntot++; if (rd_data_out[31:0] !== 32'h0) begin nbad++; $display("FAIL x0_bypass_data got=%h exp=0", rd_data_out[31:0]); end
        step();
        idle();
        #1;
        ntot++; if (rd_data_out[31:0] !== 32'h0) begin nbad++; $display("FAIL x0_data got=%h exp=0", rd_data_out[31:0]); end
        ntot++; if (rd_busy_out[0] !== 1'b0) begin nbad++; $display("FAIL x0_busy got=%b exp=0", rd_busy_out[0]); end
        ntot++; if (pending_cnt_out !== 6'd0) begin nbad++; $display("FAIL x0_pend got=%0d exp=0", pending_cnt_out); end
    endtask

    task automatic test_rename_commit();
        rename(5'd5, 4'd2);
        rd_addr_in = {5'd0, 5'd5};
        #1;
        ntot++; if (rd_busy_out[0] !== 1'b0) begin nbad++; $display("FAIL rn_same_cycle_busy got=%b exp=0", rd_busy_out[0]); end
        step();
        idle();
        #1;
        ntot++; if (rd_busy_out[0] !== 1'b1) begin nbad++; $display("FAIL rn_busy got=%b exp=1", rd_busy_out[0]); end
        ntot++; if (rd_tag_out[3:0] !== 4'd2) begin nbad++; $display("FAIL rn_tag got=%0d exp=2", rd_tag_out[3:0]); end
        ntot++; if (pending_cnt_out !== 6'd1) begin nbad++; $display("FAIL rn_pend got=%0d exp=1", pending_cnt_out); end
        commit(5'd5, 4'd2, 32'hDEAD);
        #1;
        ntot++; if (rd_data_out[31:0] !== 32'hDEAD) begin nbad++; $display("FAIL cm_bypass_data got=%h exp=dead", rd_data_out[31:0]); end
        ntot++; if (rd_busy_out[0] !== 1'b0) begin nbad++; $display("FAIL cm_bypass_busy got=%b exp=0", rd_busy_out[0]); end
        step();
        idle();
        #1;
        ntot++; if (pending_cnt_out !== 6'd0) begin nbad++; $display("FAIL cm_pend got=%0d exp=0", pending_cnt_out); end
        ntot++; if (rd_data_out[31:0] !== 32'hDEAD) begin nbad++; $display("FAIL cm_data got=%h exp=dead", rd_data_out[31:0]); end
    endtask

    task automatic test_stale_commit();
        rename(5'd7, 4'd1);
        step();
        rename(5'd7, 4'd4);
        step();
        idle();
        commit(5'd7, 4'd1, 32'd9);
        rd_addr_in = {5'd0, 5'd7};
        #1;
        ntot++; if (rd_data_out[31:0] !== 32'd9) begin nbad++; $display("FAIL stale_bypass_data got=%h exp=9", rd_data_out[31:0]); end
        ntot++; if (rd_busy_out[0] !== 1'b1) begin nbad++; $display("FAIL stale_bypass_busy got=%b exp=1", rd_busy_out[0]); end
        step();
        idle();
        #1;
        ntot++; if (rd_busy_out[0] !== 1'b1) begin nbad++; $display("FAIL stale_busy got=%b exp=1", rd_busy_out[0]); end
        ntot++; if (rd_tag_out[3:0] !== 4'd4) begin nbad++; $display("FAIL stale_tag got=%0d exp=4", rd_tag_out[3:0]); end
        ntot++; if (rd_data_out[31:0] !== 32'd9) begin nbad++; $display("FAIL stale_data got=%h exp=9", rd_data_out[31:0]); end
        ntot++; if (pending_cnt_out !== 6'd1) begin nbad++; $display("FAIL stale_pend got=%0d exp=1", pending_cnt_out); end
    endtask

    task automatic test_commit_rename_same();
        rename(5'd3, 4'd2);
        step();
        commit(5'd3, 4'd2, 32'h33);
        rename(5'd3, 4'd6);
        rd_addr_in = {5'd3, 5'd7};
        #1;
        ntot++; if (rd_busy_out[1] !== 1'b0) begin nbad++; $display("FAIL same_bypass_busy got=%b exp=0", rd_busy_out[1]); end
        step();
        idle();
        #1;
        ntot++; if (rd_busy_out[1] !== 1'b1) begin nbad++; $display("FAIL same_busy got=%b exp=1", rd_busy_out[1]); end
        ntot++; if (rd_tag_out[7:4] !== 4'd6) begin nbad++; $display("FAIL same_tag got=%0d exp=6", rd_tag_out[7:4]); end
        ntot++; if (rd_data_out[63:32] !== 32'h33) begin nbad++; $display("FAIL same_data got=%h exp=33", rd_data_out[63:32]); end
        ntot++; if (pending_cnt_out !== 6'd2) begin nbad++; $display("FAIL same_pend got=%0d exp=2", pending_cnt_out); end
    endtask

    task automatic test_stall();
        rdy_in = 1'b0;
        rename(5'd10, 4'd1);
        commit(5'd7, 4'd4, 32'h55);
        step();
        idle();
        rd_addr_in = {5'd10, 5'd7};
        #1;
        ntot++; if (rd_busy_out !== 2'b01) begin nbad++; $display("FAIL stall_busy got=%b exp=01", rd_busy_out); end
        ntot++; if (rd_data_out[31:0] !== 32'd9) begin nbad++; $display("FAIL stall_data got=%h exp=9", rd_data_out[31:0]); end
        ntot++; if (pending_cnt_out !== 6'd2) begin nbad++; $display("FAIL stall_pend got=%0d exp=2", pending_cnt_out); end
    endtask

    task automatic test_flush();
        for (int r = 11; r <= 18; r++) begin
            rename(5'(r), 4'(r - 8));
            step();
        end
        idle();
        ntot++; if (pending_cnt_out !== 6'd10) begin nbad++; $display("FAIL flush_pre_pend got=%0d exp=10", pending_cnt_out); end
        flush_in = 1'b1;
        commit(5'd4, 4'd0, 32'h11);
        rename(5'd20, 4'd3);
        step();
        idle();
        rd_addr_in = {5'd13, 5'd4};
        #1;
        ntot++; if (rd_data_out[31:0] !== 32'h11) begin nbad++; $display("FAIL flush_cm_data got=%h exp=11", rd_data_out[31:0]); end
        ntot++; if (rd_busy_out !== 2'b00) begin nbad++; $display("FAIL flush_busy got=%b exp=00", rd_busy_out); end
        ntot++; if (rd_tag_out[7:4] !== 4'd0) begin nbad++; $display("FAIL flush_tag got=%0d exp=0", rd_tag_out[7:4]); end
        ntot++; if (pending_cnt_out !== 6'd0) begin nbad++; $display("FAIL flush_pend got=%0d exp=0", pending_cnt_out); end
        rd_addr_in = {5'd7, 5'd20};
        #1;
        ntot++; if (rd_busy_out !== 2'b00) begin nbad++; $display("FAIL flush_rn_busy got=%b exp=00", rd_busy_out); end
    endtask

    task automatic test_back_to_back();
        rename(5'd1, 4'd7);
        step();
        rename(5'd2, 4'd8);
        rd_addr_in = {5'd2, 5'd1};
        #1;
        ntot++; if (rd_busy_out !== 2'b01) begin nbad++; $display("FAIL b2b_busy0 got=%b exp=01", rd_busy_out); end
        ntot++; if (rd_tag_out[3:0] !== 4'd7) begin nbad++; $display("FAIL b2b_tag0 got=%0d exp=7", rd_tag_out[3:0]); end
        step();
        idle();
        #1;
        ntot++; if (rd_busy_out !== 2'b11) begin nbad++; $display("FAIL b2b_busy1 got=%b exp=11", rd_busy_out); end
        ntot++; if (rd_tag_out !== 8'h87) begin nbad++; $display("FAIL b2b_tags got=%h exp=87", rd_tag_out); end
        ntot++; if (pending_cnt_out !== 6'd2) begin nbad++; $display("FAIL b2b_pend got=%0d exp=2", pending_cnt_out); end
    endtask

`ifdef REGFILE_CKPT_EN
    task automatic test_checkpoint();
        rename(5'd8, 4'd2);
        step();
        idle();
        ck_save_in = 1'b1;
        ck_id_in   = 2'd1;
        step();
        idle();
        commit(5'd8, 4'd2, 32'h77);
        step();
        idle();
        rename(5'd9, 4'd5);
        step();
        idle();
        rd_addr_in = {5'd9, 5'd8};
        #1;
        ntot++; if (rd_busy_out !== 2'b10) begin nbad++; $display("FAIL ck_pre_busy got=%b exp=10", rd_busy_out); end
        ck_restore_in = 1'b1;
        ck_rid_in     = 2'd1;
        step();
        idle();
        #1;
        ntot++; if (rd_busy_out !== 2'b00) begin nbad++; $display("FAIL ck_restore_busy got=%b exp=00", rd_busy_out); end
        ntot++; if (pending_cnt_out !== 6'd2) begin nbad++; $display("FAIL ck_pend got=%0d exp=2", pending_cnt_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_x0();
        test_rename_commit();
        test_stale_commit();
        test_commit_rename_same();
        test_stall();
        test_flush();
        test_back_to_back();
`ifdef REGFILE_CKPT_EN
        test_checkpoint();
`endif
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
